ahb_arb2: RTL and testbench

Two-master AHB-Lite arbiter/interconnect placed in front of the testbench AHB memory slave so that two masters (e.g. IFU and LSU ports) can share one slave. Each master port has an address-capture stage, so a master that loses arbitration is stalled in its data phase rather than in its address phase. A round-robin arbiter with burst lock sequences captured and live transfers onto the single slave bus. Data-phase signals are routed back to the owning master.

---
 rtl/ahb_arb2.sv | 179 +++++++++++++++++
 tb/tb_ahb_arb2.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arb2.sv
// Two-master AHB-Lite arbiter in front of a single slave. Each master has a
// one-deep address hold register, so a losing master stalls in its data phase.
`timescale 1ns/1ps
module ahb_arb2 #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          HCLK,
    input  logic          HRESET,

    input  logic [AW-1:0] M0_HADDR,
    input  logic [1:0]    M0_HTRANS,
    input  logic          M0_HWRITE,
    input  logic [2:0]    M0_HSIZE,
    input  logic [2:0]    M0_HBURST,
    input  logic [3:0]    M0_HPROT,
    input  logic [DW-1:0] M0_HWDATA,
    output logic          M0_HREADY,
    output logic          M0_HRESP,
    output logic [DW-1:0] M0_HRDATA,

    input  logic [AW-1:0] M1_HADDR,
    input  logic [1:0]    M1_HTRANS,
    input  logic          M1_HWRITE,
    input  logic [2:0]    M1_HSIZE,
    input  logic [2:0]    M1_HBURST,
    input  logic [3:0]    M1_HPROT,
    input  logic [DW-1:0] M1_HWDATA,
    output logic          M1_HREADY,
    output logic          M1_HRESP,
    output logic [DW-1:0] M1_HRDATA,

    output logic          S_HSEL,
    output logic [AW-1:0] S_HADDR,
    output logic [1:0]    S_HTRANS,
    output logic          S_HWRITE,
    output logic [2:0]    S_HSIZE,
    output logic [2:0]    S_HBURST,
    output logic [3:0]    S_HPROT,
    output logic [DW-1:0] S_HWDATA,
    output logic          S_HREADY,
    input  logic          S_HREADYOUT,
    input  logic          S_HRESP,
    input  logic [DW-1:0] S_HRDATA
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [3:0]    prot;
    } req_t;

    localparam logic [1:0] TR_IDLE = 2'b00;
    localparam logic [1:0] TR_BUSY = 2'b01;
    localparam logic [1:0] TR_SEQ  = 2'b11;

    req_t       live [2];
    req_t       hold_q [2];
    req_t       win_req;
    logic [1:0] hold_vld;
    logic [1:0] mready;
    logic [1:0] live_acc;
    logic [1:0] pend;
    logic       dph_vld;
    logic       dph_own;
    logic       last_gnt;
    logic       slot_free;
    logic       lock;
    logic       issue;
    logic       winner;
    logic [1:0] lg_trans;

    always_comb begin
        live[0].addr  = M0_HADDR;
        live[0].trans = M0_HTRANS;
        live[0].write = M0_HWRITE;
        live[0].size  = M0_HSIZE;
        live[0].burst = M0_HBURST;
        live[0].prot  = M0_HPROT;
        live[1].addr  = M1_HADDR;
        live[1].trans = M1_HTRANS;
        live[1].write = M1_HWRITE;
        live[1].size  = M1_HSIZE;
        live[1].burst = M1_HBURST;
        live[1].prot  = M1_HPROT;
    end

    always_comb begin
        mready   = 2'b00;
        live_acc = 2'b00;
        pend     = 2'b00;
        for (int n = 0; n < 2; n++) begin
            mready[n]   = (dph_vld && dph_own == 1'(n)) ? S_HREADYOUT : !hold_vld[n];
            live_acc[n] = live[n].trans[1] & mready[n];
            pend[n]     = hold_vld[n] | live_acc[n];
        end
    end

    // The slave holds HREADYOUT low while idle, so it only matters during a data phase.
    assign slot_free = !dph_vld || S_HREADYOUT;
    assign lg_trans  = live[last_gnt].trans;
    assign lock      = !hold_vld[last_gnt] && (lg_trans == TR_SEQ || lg_trans == TR_BUSY);

    always_comb begin
        issue  = 1'b0;
        winner = 1'b0;
        if (slot_free && !HRESET) begin
            if (lock) begin
                issue  = 1'b1;
                winner = last_gnt;
            end else if (pend == 2'b11) begin
                issue  = 1'b1;
                winner = !last_gnt;
            end else if (pend[0]) begin
                issue  = 1'b1;
                winner = 1'b0;
            end else if (pend[1]) begin
                issue  = 1'b1;
                winner = 1'b1;
            end
        end
    end

    assign win_req = hold_vld[winner] ? hold_q[winner] : live[winner];

    assign S_HSEL   = issue;
    assign S_HTRANS = issue ? win_req.trans : TR_IDLE;
    assign S_HADDR  = win_req.addr;
    assign S_HWRITE = win_req.write;
    assign S_HSIZE  = win_req.size;
    assign S_HBURST = win_req.burst;
    assign S_HPROT  = win_req.prot;
    assign S_HWDATA = dph_own ? M1_HWDATA : M0_HWDATA;
    assign S_HREADY = dph_vld ? S_HREADYOUT : 1'b1;

    assign M0_HREADY = mready[0];
    assign M1_HREADY = mready[1];
    assign M0_HRESP  = dph_vld && !dph_own && S_HRESP;
    assign M1_HRESP  = dph_vld && dph_own && S_HRESP;
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;

    // A locked BUSY beat owns the grant but opens no slave data phase.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            hold_vld <= 2'b00;
            dph_vld  <= 1'b0;
            dph_own  <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            if (slot_free) begin
                dph_vld <= issue && win_req.trans[1];
                if (issue) begin
                    dph_own  <= winner;
                    last_gnt <= winner;
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (issue && winner == 1'(n)) begin
                    hold_vld[n] <= 1'b0;
                end else if (live_acc[n]) begin
                    hold_vld[n] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        for (int n = 0; n < 2; n++) begin
            if (live_acc[n] && !(issue && winner == 1'(n))) begin
                hold_q[n] <= live[n];
            end
        end
    end

endmodule

// File: tb/tb_ahb_arb2.sv
// Directed bench for ahb_arb2: two master models, a memory slave with stall
// control, and an expected slave-address-order scoreboard.
`timescale 1ns/1ps
module tb_ahb_arb2;
    localparam int AW = 32;
    localparam int DW = 64;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic [AW-1:0] M0_HADDR, M1_HADDR, S_HADDR;
    logic [1:0]    M0_HTRANS, M1_HTRANS, S_HTRANS;
    logic          M0_HWRITE, M1_HWRITE, S_HWRITE;
    logic [2:0]    M0_HSIZE, M1_HSIZE, S_HSIZE, M0_HBURST, M1_HBURST, S_HBURST;
    logic [3:0]    M0_HPROT, M1_HPROT, S_HPROT;
    logic [DW-1:0] M0_HWDATA, M1_HWDATA, S_HWDATA, M0_HRDATA, M1_HRDATA, S_HRDATA;
    logic          M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
    logic          S_HSEL, S_HREADY, S_HREADYOUT, S_HRESP;

    ahb_arb2 #(.AW(AW), .DW(DW)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
        .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HWDATA(M0_HWDATA),
        .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
        .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HWDATA(M1_HWDATA),
        .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
        .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE),
        .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HWDATA(S_HWDATA),
        .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    burst;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rexp;
    } xfer_t;

    xfer_t         mq0[$];
    xfer_t         mq1[$];
    xfer_t         a_tr [2];
    xfer_t         d_tr [2];
    logic [1:0]    a_vld = 2'b00;
    logic [1:0]    d_vld = 2'b00;
    logic [1:0]    hr = 2'b11;
    logic [AW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          stall = 1'b0;
    logic          err = 1'b0;

    // Master pins follow the model: address phase from a_tr, write data from d_tr.
    always_comb begin
        M0_HADDR  = a_tr[0].addr;
        M0_HTRANS = a_vld[0] ? a_tr[0].trans : 2'b00;
        M0_HWRITE = a_tr[0].write;
        M0_HSIZE  = 3'b011;
        M0_HBURST = a_tr[0].burst;
        M0_HPROT  = 4'b0011;
        M0_HWDATA = d_vld[0] ? d_tr[0].wdata : '0;
        M1_HADDR  = a_tr[1].addr;
        M1_HTRANS = a_vld[1] ? a_tr[1].trans : 2'b00;
        M1_HWRITE = a_tr[1].write;
        M1_HSIZE  = 3'b011;
        M1_HBURST = a_tr[1].burst;
        M1_HPROT  = 4'b0011;
        M1_HWDATA = d_vld[1] ? d_tr[1].wdata : '0;
    end

    logic [DW-1:0] mem [0:63];
    logic          s_dvld, s_write;
    logic [5:0]    s_idx;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s_dvld <= 1'b0;
        end else if (S_HREADY) begin
            if (s_dvld && s_write) mem[s_idx] <= S_HWDATA;
            s_dvld  <= S_HSEL && S_HTRANS[1];
            s_write <= S_HWRITE;
            s_idx   <= S_HADDR[8:3];
        end
    end

    assign S_HREADYOUT = s_dvld && !stall;
    assign S_HRESP     = s_dvld && err;
    assign S_HRDATA    = (s_dvld && !s_write) ? mem[s_idx] : '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int n, input logic [AW-1:0] addr, input logic [1:0] trans,
                        input logic wr, input logic [2:0] burst, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rexp);
        xfer_t t;
        t.addr = addr; t.trans = trans; t.write = wr; t.burst = burst; t.wdata = wd; t.rexp = rexp;
        if (n == 0) mq0.push_back(t);
        else mq1.push_back(t);
    endtask

    task automatic samp();
        logic [AW-1:0] e;
        @(negedge HCLK);
        hr = {M1_HREADY, M0_HREADY};
        if (S_HSEL && S_HTRANS[1] && S_HREADY) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed addr=%0h expected no transfer", S_HADDR);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_order", 64'(S_HADDR), 64'(e));
            end
        end
        for (int n = 0; n < 2; n++) begin
            if (hr[n] && d_vld[n] && !d_tr[n].write)
                chk("rdata", (n == 0) ? M0_HRDATA : M1_HRDATA, d_tr[n].rexp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
        for (int n = 0; n < 2; n++) begin
            if (hr[n]) begin
                d_vld[n] = a_vld[n];
                d_tr[n]  = a_tr[n];
                a_vld[n] = 1'b0;
                if (n == 0 && mq0.size() > 0) begin a_tr[0] = mq0.pop_front(); a_vld[0] = 1'b1; end
                if (n == 1 && mq1.size() > 0) begin a_tr[1] = mq1.pop_front(); a_vld[1] = 1'b1; end
            end
        end
    endtask

    task automatic cyc();
        samp();
        tick();
    endtask

    task automatic drain(input string tag);
        logic busy;
        for (int i = 0; i < 60; i++) begin
            busy = (mq0.size() != 0) || (mq1.size() != 0) || (a_vld != 2'b00) || (d_vld != 2'b00);
            if (!busy) break;
            cyc();
        end
        busy = (mq0.size() != 0) || (mq1.size() != 0) || (a_vld != 2'b00) || (d_vld != 2'b00);
        chk({tag, "_drain"}, 64'(busy), 64'd0);
        chk({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_m0_hready", 64'(M0_HREADY), 64'd1);
        chk("rst_m1_hready", 64'(M1_HREADY), 64'd1);
        chk("rst_s_hsel", 64'(S_HSEL), 64'd0);
        chk("rst_s_htrans", 64'(S_HTRANS), 64'd0);
        HRESET = 1'b0;
        samp();
        chk("idle_m0_hresp", 64'(M0_HRESP), 64'd0);
        chk("idle_m1_hresp", 64'(M1_HRESP), 64'd0);
        chk("idle_s_hsel", 64'(S_HSEL), 64'd0);
        tick();

        // Collision after reset: M0 live, M1 captured and issued next cycle.
        send(0, 32'h000, 2'b10, 1'b1, 3'b000, 64'h0A0A, '0);
        send(1, 32'h100, 2'b10, 1'b1, 3'b000, 64'h0B0B, '0);
        exp_q.push_back(32'h000);
        exp_q.push_back(32'h100);
        cyc();
        samp();
        chk("col_m0_live_addr", 64'(S_HADDR), 64'h000);
        chk("col_m1_accept", 64'(M1_HREADY), 64'd1);
        tick();
        samp();
        chk("col_m1_issue_addr", 64'(S_HADDR), 64'h100);
        chk("col_m1_issue_trans", 64'(S_HTRANS), 64'd2);
        chk("col_m1_wait", 64'(M1_HREADY), 64'd0);
        tick();
        samp();
        chk("col_m1_dph_ready", 64'(M1_HREADY), 64'd1);
        tick();
        drain("col");

        // Round robin: both masters stream 4 writes each.
        for (int i = 0; i < 4; i++) begin
            send(0, 32'h000 + 32'(8 * i), 2'b10, 1'b1, 3'b000, 64'hA0A0_0000_0000_0000 + 64'(i), '0);
            send(1, 32'h100 + 32'(8 * i), 2'b10, 1'b1, 3'b000, 64'hB1B1_0000_0000_0000 + 64'(i), '0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h000 + 32'(8 * i));
            exp_q.push_back(32'h100 + 32'(8 * i));
        end
        drain("rr");

        // Slave stall with M1 held behind an M0 data phase.
        send(0, 32'h030, 2'b10, 1'b1, 3'b000, 64'h3030, '0);
        send(1, 32'h130, 2'b10, 1'b1, 3'b000, 64'h3131, '0);
        exp_q.push_back(32'h030);
        exp_q.push_back(32'h130);
        cyc();
        samp();
        chk("stl_m0_live", 64'(S_HADDR), 64'h030);
        tick();
        stall = 1'b1;
        err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("stl_m0_hready", 64'(M0_HREADY), 64'd0);
            chk("stl_m1_hready", 64'(M1_HREADY), 64'd0);
            chk("stl_m0_hresp", 64'(M0_HRESP), 64'd1);
            chk("stl_m1_hresp", 64'(M1_HRESP), 64'd0);
            chk("stl_no_issue", 64'(S_HSEL), 64'd0);
            tick();
        end
        stall = 1'b0;
        samp();
        chk("stl_m1_issue_addr", 64'(S_HADDR), 64'h130);
        chk("stl_m1_issue_trans", 64'(S_HTRANS), 64'd2);
        chk("stl_m0_done", 64'(M0_HREADY), 64'd1);
        chk("stl_m1_hresp_done", 64'(M1_HRESP), 64'd0);
        tick();
        err = 1'b0;
        drain("stl");

        // Reset while M1 is held and M0 is stalled in its data phase.
        send(0, 32'h040, 2'b10, 1'b1, 3'b000, 64'h4040, '0);
        send(1, 32'h140, 2'b10, 1'b1, 3'b000, 64'h4141, '0);
        exp_q.push_back(32'h040);
        cyc();
        samp();
        chk("rmo_m0_live", 64'(S_HADDR), 64'h040);
        tick();
        stall = 1'b1;
        samp();
        chk("rmo_m1_held", 64'(M1_HREADY), 64'd0);
        chk("rmo_m0_stall", 64'(M0_HREADY), 64'd0);
        #2;
        HRESET = 1'b1;
        a_vld = 2'b00;
        d_vld = 2'b00;
        mq0.delete();
        mq1.delete();
        exp_q.delete();
        stall = 1'b0;
        #1;
        chk("rmo_s_htrans", 64'(S_HTRANS), 64'd0);
        chk("rmo_s_hsel", 64'(S_HSEL), 64'd0);
        chk("rmo_m0_hready", 64'(M0_HREADY), 64'd1);
        chk("rmo_m1_hready", 64'(M1_HREADY), 64'd1);
        hr = 2'b11;
        tick();
        HRESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            samp();
            chk("rmo_quiet", 64'(S_HSEL), 64'd0);
            tick();
        end

        // Single master: write then read back with no added latency.
        send(0, 32'h000, 2'b10, 1'b1, 3'b000, 64'h1122334455667788, '0);
        send(0, 32'h000, 2'b10, 1'b0, 3'b000, '0, 64'h1122334455667788);
        send(0, 32'h108, 2'b10, 1'b0, 3'b000, '0, 64'hB1B1_0000_0000_0001);
        exp_q.push_back(32'h000);
        exp_q.push_back(32'h000);
        exp_q.push_back(32'h108);
        cyc();
        samp();
        chk("sm_zero_lat_trans", 64'(S_HTRANS), 64'd2);
        chk("sm_zero_lat_addr", 64'(S_HADDR), 64'h000);
        chk("sm_m0_hready_a", 64'(M0_HREADY), 64'd1);
        tick();
        samp();
        chk("sm_hwdata", S_HWDATA, 64'h1122334455667788);
        chk("sm_m0_hready_b", 64'(M0_HREADY), 64'd1);
        tick();
        drain("sm");

        // Burst lock: M1 INCR4 stays contiguous while M0 waits.
        send(1, 32'h100, 2'b10, 1'b1, 3'b011, 64'hC0, '0);
        for (int i = 1; i < 4; i++)
            send(1, 32'h100 + 32'(8 * i), 2'b11, 1'b1, 3'b011, 64'hC0 + 64'(i), '0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(8 * i));
        exp_q.push_back(32'h020);
        cyc();
        send(0, 32'h020, 2'b10, 1'b1, 3'b000, 64'hD0, '0);
        samp();
        chk("bl_beat0", 64'(S_HADDR), 64'h100);
        tick();
        for (int i = 1; i < 4; i++) begin
            samp();
            chk("bl_beat_addr", 64'(S_HADDR), 64'h100 + 64'(8 * i));
            chk("bl_beat_seq", 64'(S_HTRANS), 64'd3);
            tick();
        end
        samp();
        chk("bl_m0_after", 64'(S_HADDR), 64'h020);
        chk("bl_m0_after_trans", 64'(S_HTRANS), 64'd2);
        tick();
        drain("bl");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
